// File: rtl/hazard_controller.sv
// hazard_controller: load-use/memory-wait/mispredict hazard sequencer with saturating perf counters
module hazard_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_valid,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_load_en,
  input  logic             i_ex_wren,
  input  logic             i_ex_valid,
  input  logic             i_mispredict,
  input  logic             i_lsu_req,
  input  logic             i_lsu_ready,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic             o_mem_timeout,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, FLUSH = 2'b10} state_t;
  state_t state_q, state_d;
  logic ret_flush_q, ret_flush_d, timeout_q, timeout_d;
  logic [FW-1:0] rem_q, rem_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic load_use, mem_busy, stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_acc;
  assign load_use = i_ex_valid & i_ex_load_en & i_ex_wren & (i_ex_rd_addr != 5'd0) & i_id_valid &
                    ((i_id_use_rs1 & (i_id_rs1_addr == i_ex_rd_addr)) |
                     (i_id_use_rs2 & (i_id_rs2_addr == i_ex_rd_addr)));
  assign mem_busy = i_lsu_req & ~i_lsu_ready;
  // Next state and hazard controls; memory stall outranks mispredict, which outranks load-use
  always_comb begin
    state_d = state_q;
    ret_flush_d = ret_flush_q;
    rem_d = rem_q;
    wait_d = '0;
    {stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_acc} = '0;
    if (mem_busy) begin
      {stall_if, stall_id, stall_ex} = 3'b111;
      state_d = MEM_WAIT;
      wait_d = (wait_q == WW'(MEM_TIMEOUT)) ? wait_q : wait_q + 1'b1;
      ret_flush_d = (state_q == MEM_WAIT) ? ret_flush_q : (state_q == FLUSH);
    end else if (state_q == MEM_WAIT) begin
      {stall_if, stall_id, stall_ex} = 3'b111;
      state_d = ret_flush_q ? FLUSH : RUN;
    end else if (i_mispredict) begin
      {flush_id, flush_ex, flush_acc} = 3'b111;
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      rem_d = FW'(FLUSH_CYCLES - 1);
    end else if (state_q == FLUSH) begin
      flush_id = 1'b1;
      rem_d = rem_q - 1'b1;
      state_d = (rem_q <= FW'(1)) ? RUN : FLUSH;
    end else if (load_use) begin
      {stall_if, stall_id, flush_ex} = 3'b111;
    end
    timeout_d = timeout_q | (wait_d == WW'(MEM_TIMEOUT));
    stall_cnt_d = stall_cnt_q + CNT_W'(o_stall_if & ~&stall_cnt_q);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_acc & ~i_reset & ~&flush_cnt_q);
  end
  // State, wait/flush sequencing and performance counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RUN;
      ret_flush_q <= 1'b0;
      rem_q <= '0;
      wait_q <= '0;
      timeout_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ret_flush_q <= ret_flush_d;
      rem_q <= rem_d;
      wait_q <= wait_d;
      timeout_q <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign o_stall_if = stall_if & ~i_reset;
  assign o_stall_id = stall_id & ~i_reset;
  assign o_stall_ex = stall_ex & ~i_reset;
  assign o_flush_id = flush_id & ~i_reset;
  assign o_flush_ex = flush_ex & ~i_reset;
  assign o_mem_timeout = timeout_q;
  assign o_state = state_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed checks of hazard_controller (default and FLUSH_CYCLES=3 instances)
module tb_hazard_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic use1 = 0, use2 = 0, id_v = 0, ld = 0, wr = 0, ex_v = 0, mis = 0, req = 0, rdy = 0;
  logic a_sif, a_sid, a_sex, a_fid, a_fex, a_to, b_sif, b_sid, b_sex, b_fid, b_fex, b_to;
  logic [1:0] a_st, b_st;
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  hazard_controller u_a (
    .i_clk(clk), .i_reset(rst), .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_use_rs1(use1),
    .i_id_use_rs2(use2), .i_id_valid(id_v), .i_ex_rd_addr(rd), .i_ex_load_en(ld), .i_ex_wren(wr),
    .i_ex_valid(ex_v), .i_mispredict(mis), .i_lsu_req(req), .i_lsu_ready(rdy),
    .o_stall_if(a_sif), .o_stall_id(a_sid), .o_stall_ex(a_sex), .o_flush_id(a_fid), .o_flush_ex(a_fex),
    .o_mem_timeout(a_to), .o_state(a_st), .o_stall_cnt(a_sc), .o_flush_cnt(a_fc));
  hazard_controller #(.FLUSH_CYCLES(3)) u_b (
    .i_clk(clk), .i_reset(rst), .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_use_rs1(use1),
    .i_id_use_rs2(use2), .i_id_valid(id_v), .i_ex_rd_addr(rd), .i_ex_load_en(ld), .i_ex_wren(wr),
    .i_ex_valid(ex_v), .i_mispredict(mis), .i_lsu_req(req), .i_lsu_ready(rdy),
    .o_stall_if(b_sif), .o_stall_id(b_sid), .o_stall_ex(b_sex), .o_flush_id(b_fid), .o_flush_ex(b_fex),
    .o_mem_timeout(b_to), .o_state(b_st), .o_stall_cnt(b_sc), .o_flush_cnt(b_fc));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    mis = 1; req = 1;
    #2;
    chk("rst_ctl_a", {a_sif, a_sid, a_sex, a_fid, a_fex}, 5'b0);
    chk("rst_state_a", a_st, 2'b00);
    chk("rst_cnt_a", {a_sc, a_fc, 15'b0, a_to}, 32'b0);
    chk("rst_ctl_b", {b_sif, b_fid, b_fex}, 3'b0);
    tick(); mis = 0; req = 0; rst = 0;
    tick();
    ex_v = 1; ld = 1; wr = 1; rd = 5; id_v = 1; rs1 = 5; use1 = 1; rs2 = 1; use2 = 1; #2;
    chk("lu_ctl", {a_sif, a_sid, a_sex, a_fid, a_fex}, 5'b11001);
    tick(); ex_v = 0; #2;
    chk("lu_clear", {a_sif, a_sid, a_fex}, 3'b000);
    chk("lu_cnt", a_sc, 16'd1);
    ex_v = 1; rd = 0; rs1 = 0; #2;
    chk("x0_nohaz", {a_sif, a_fex}, 2'b00);
    rd = 5; rs1 = 1; rs2 = 5; use2 = 0; #2;
    chk("rs2_unused", {a_sif, a_fex}, 2'b00);
    use2 = 1; #2;
    chk("rs2_haz", {a_sif, a_sid, a_fex}, 3'b111);
    tick(); ex_v = 0; req = 1; rdy = 0; #2;
    chk("mem_c1", {a_st, a_sif, a_sid, a_sex, a_fex}, {2'b00, 4'b1110});
    tick(); #2;
    chk("mem_c2", {a_st, a_sif, a_sid, a_sex}, {2'b01, 3'b111});
    tick(); #2;
    chk("mem_c3", {a_st, a_sex}, {2'b01, 1'b1});
    tick(); rdy = 1; #2;
    chk("mem_c4", {a_st, a_sif, a_sid, a_sex}, {2'b01, 3'b111});
    tick(); req = 0; rdy = 0; #2;
    chk("mem_done", {a_st, a_sif, a_sex}, {2'b00, 2'b00});
    chk("mem_cnt", a_sc, 16'd6);
    mis = 1; req = 1; #2;
    chk("mis_busy", {a_sif, a_sex, a_fid, a_fex}, 4'b1100);
    tick(); rdy = 1; #2;
    chk("mis_wait", {a_st, a_sif, a_fid, a_fex}, {2'b01, 3'b100});
    tick(); req = 0; rdy = 0; #2;
    chk("mis_take", {a_st, a_sif, a_fid, a_fex}, {2'b00, 3'b011});
    tick(); mis = 0; #2;
    chk("mis_after", {a_fid, a_fex, a_st}, 4'b0000);
    chk("mis_cnts", {a_sc, a_fc}, {16'd8, 16'd1});
    tick(); tick(); tick();
    chk("b_idle", {b_st, b_fid}, 3'b000);
    mis = 1; #2;
    chk("b_f1", {b_fid, b_fex, b_sif}, 3'b110);
    tick(); mis = 0; #2;
    chk("b_f2", {b_st, b_fid, b_fex}, {2'b10, 2'b10});
    tick(); #2;
    chk("b_f3", {b_st, b_fid, b_fex}, {2'b10, 2'b10});
    tick(); #2;
    chk("b_f4", {b_st, b_fid, b_fex}, {2'b00, 2'b00});
    chk("b_fcnt", b_fc, 16'd2);
    chk("a_fcnt", {a_fc, 14'b0, a_st}, {16'd2, 16'd0});
    mis = 1; tick(); mis = 0; #2;
    chk("b_rst_pre", {b_st, b_fid}, 3'b101);
    rst = 1; #1;
    chk("b_rst_async", {b_st, b_fid, b_fex}, 4'b0000);
    chk("rst_cnts", {a_sc, b_fc}, 32'b0);
    tick(); rst = 0; #2;
    chk("b_rst_rel", {b_st, b_fid}, 3'b000);
    tick(); #2;
    chk("b_rst_noresid", {b_st, b_fid}, 3'b000);
    req = 1; rdy = 0;
    for (int i = 0; i < 15; i++) tick();
    #2;
    chk("to_15", {a_to, a_st}, 3'b001);
    tick(); #2;
    chk("to_16", {a_to, a_sex}, 2'b11);
    tick(); tick(); tick(); #2;
    chk("to_19", {a_to, a_st, a_sif}, 4'b1011);
    rdy = 1; #2;
    chk("to_ready", {a_to, a_st, a_sif}, 4'b1011);
    tick(); req = 0; rdy = 0; #2;
    chk("to_sticky", {a_to, a_st, a_sif}, 4'b1000);
    chk("to_cnt", a_sc, 16'd20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
